// File: rtl/axilite_reg_rd.sv
// AXI4-Lite read slave: turns one AR/R transaction at a time into a register read strobe.
// Latency: 3 cycles minimum per read. Backpressure: arready is low until R completes; a silent register file times out with SLVERR.
module axilite_reg_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 40,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [ADDR_WIDTH-1:0] reg_rd_addr,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_wait,
    input  logic                  reg_rd_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Protection attributes carry no meaning for the register space.
    logic unused_prot;
    assign unused_prot = ^s_axil_arprot;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            s_axil_arready <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rvalid  <= 1'b0;
            reg_rd_addr    <= '0;
            reg_rd_en      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axil_arvalid && s_axil_arready) begin
                        reg_rd_addr    <= s_axil_araddr;
                        cnt            <= CNT_LOAD;
                        s_axil_arready <= 1'b0;
                        reg_rd_en      <= 1'b1;
                        state          <= ACCESS;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                ACCESS: begin
                    // An ack on the last budgeted cycle still returns real data.
                    if (reg_rd_ack) begin
                        s_axil_rdata  <= reg_rd_data;
                        s_axil_rresp  <= RESP_OKAY;
                        s_axil_rvalid <= 1'b1;
                        reg_rd_en     <= 1'b0;
                        state         <= RESP;
                    end else if (cnt == '0) begin
                        s_axil_rdata  <= '0;
                        s_axil_rresp  <= RESP_SLVERR;
                        s_axil_rvalid <= 1'b1;
                        reg_rd_en     <= 1'b0;
                        state         <= RESP;
                    end else if (!reg_rd_wait) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    s_axil_arready <= 1'b0;
                    s_axil_rvalid  <= 1'b0;
                    reg_rd_en      <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axilite_reg_rd.md
# axilite_reg_rd

AXI4-Lite read slave that converts AR/R channel transactions into a simple register read strobe interface. It is the read-side companion of the AXI-Lite write-to-register bridge, and the two together form a full AXI-Lite register port for the accelerator configuration/status space. It allows one outstanding read, has a bounded-latency timeout, and returns SLVERR when the register file never acknowledges.

## Interface

- DATA_WIDTH, 32, width of s_axil_rdata and reg_rd_data
- ADDR_WIDTH, 40, width of s_axil_araddr and reg_rd_addr
- TIMEOUT, 4, number of non-waiting ACCESS cycles before a forced completion; legal range ≥ 1; counter width is max(1, $clog2(TIMEOUT))

Reset is asynchronous and active-low. There is one clock.

- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1  address valid
- s_axil_arready  out  1  address ready (registered)
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR on timeout
- s_axil_rvalid  out  1  read response valid
- s_axil_rready  in  1  read response ready
- reg_rd_addr  out  ADDR_WIDTH  captured address
- reg_rd_en  out  1  read request level, high for the whole ACCESS state
- reg_rd_data  in  DATA_WIDTH  register data, sampled in the cycle reg_rd_ack is high
- reg_rd_wait  in  1  high freezes the timeout counter
- reg_rd_ack  in  1  register read complete

## Operation

- FSM states: IDLE, ACCESS, RESP. All outputs come straight from flops; there is no combinational path from inputs to outputs.
- **IDLE**
  - s_axil_arready=1.
  - On arvalid&&arready: latch araddr into reg_rd_addr, load the counter with TIMEOUT-1, then go to ACCESS.
  - arready=0 from the next cycle.
- **ACCESS**
  - reg_rd_en=1.
  - Each cycle, in priority order:
    - reg_rd_ack=1: latch reg_rd_data into rdata, set rresp=00 and rvalid=1, then go to RESP.
    - Otherwise, counter==0: set rdata=0, rresp=10 and rvalid=1, then go to RESP.
    - Otherwise, reg_rd_wait=0: decrement the counter.
    - Otherwise: hold the counter.
- **RESP**
  - rvalid=1, and rdata/rresp stay stable until rready.
  - On rvalid&&rready: clear rvalid and go to IDLE; arready=1 in the following cycle.
- A held reg_rd_wait=1 with no ack stalls ACCESS indefinitely, by design.
- reg_rd_ack in IDLE or RESP is ignored.
- reg_rd_addr holds the last address between transactions.
- arvalid while arready=0 is not accepted; the master holds it per AXI.

## Timing

- Reset values: arready=0, rvalid=0, rdata=0, rresp=00, reg_rd_en=0, reg_rd_addr=0, state=IDLE.
- arready rises on the first clk edge after rstn deasserts.
- Reset mid-transaction: reg_rd_en and rvalid drop immediately, asynchronously. The transaction is discarded and no response is issued.
- AR handshake at edge N:
  - reg_rd_en=1 after edge N+1.
  - With ack in that cycle: reg_rd_en=0 and rvalid=1 after edge N+2.
  - With rready=1: rvalid=0 and arready=1 after edge N+3.
  - Minimum period is 3 cycles per read.
- Timeout with wait=0 and no ack: reg_rd_en stays high for exactly TIMEOUT cycles, then rvalid rises.
- ack and counter==0 in the same cycle: ack wins and the response is OKAY with real data.
- rvalid never deasserts without rready, and rdata/rresp do not change while rvalid=1.

## Test plan

- **Reset release.** Reset for 5 cycles, then release.
  - During reset, all outputs are at reset values.
  - arready=1 one cycle after release.
- **Basic read.** araddr=0x40, reg_rd_data=0xDEADBEEF, ack tied 1, rready=1.
  - reg_rd_addr=0x40.
  - reg_rd_en is high for 1 cycle.
  - rvalid rises 2 cycles after the AR handshake, with rdata=0xDEADBEEF and rresp=00.
  - Back-to-back reads complete every 3 cycles.
- **Backpressure.** rready=0 for 6 cycles after rvalid.
  - rvalid, rdata and rresp are stable throughout.
  - arready=0 throughout; a pending arvalid is not accepted.
  - Completion follows 1 cycle after rready rises.
- **Timeout.** TIMEOUT=4, ack=0, wait=0.
  - reg_rd_en is high for exactly 4 cycles.
  - Then rvalid=1, rresp=10, rdata=0.
- **Wait stall.** wait=1 for 10 cycles, then ack=1 with reg_rd_data=0x1234.
  - No timeout occurs.
  - rresp=00, rdata=0x1234.
- **Reset mid-operation.** Assert rstn low during ACCESS, then during RESP.
  - Outputs return to reset values asynchronously.
  - After release, a normal read completes correctly.
